// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared constants and width helpers for the round-robin register arbiter.
package dff_arb_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int GNT_CNT_W = 8;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int burst_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester/register bus of the arbiter.
// gnt_cnt exists only when ARB_GNT_COUNT_EN is defined.
interface dff_bank_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0] q;
  logic wr_pulse;
  logic busy;
`ifdef ARB_GNT_COUNT_EN
  logic [NUM_REQ*GNT_CNT_W-1:0] gnt_cnt;
  modport master (output req, wdata, input gnt, q, wr_pulse, busy, gnt_cnt);
  modport slave (input req, wdata, output gnt, q, wr_pulse, busy, gnt_cnt);
`else
  modport master (output req, wdata, input gnt, q, wr_pulse, busy);
  modport slave (input req, wdata, output gnt, q, wr_pulse, busy);
`endif
endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit at or above ptr with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W:0] s;
  logic [IDX_W-1:0] j;
  // Scan from the farthest offset down so the nearest candidate to ptr wins.
  always_comb begin
    pick = '0;
    idx = '0;
    s = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IDX_W + 1)'(k);
      j = s >= (IDX_W + 1)'(NUM_REQ) ? IDX_W'(s - (IDX_W + 1)'(NUM_REQ)) : IDX_W'(s);
      pick = req[j] ? NUM_REQ'(1) << j : pick;
      idx = req[j] ? j : idx;
    end
  end
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter for one shared register with burst-limited ownership.
// Optional per-requester grant counters are enabled by ARB_GNT_COUNT_EN.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  dff_bank_arbiter_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int BURST_W = burst_w(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  logic state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
  logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
  logic [DATA_W-1:0] q_q, q_d, wsel;
  logic wr_pulse_q, wr_pulse_d, grant, write, rotate, rel;
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .pick(pick),
    .idx (pick_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      burst_q <= '0;
      q_q <= '0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      burst_q <= burst_d;
      q_q <= q_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end
  // A forced rotation writes and releases on the same edge, so every handover costs one idle cycle.
  always_comb begin
    grant = state_q == ST_IDLE && |bus.req;
    write = state_q == ST_GRANT && bus.req[owner_q];
    burst_inc = burst_q == BURST_MAX ? burst_q : burst_q + 1'b1;
    rotate = write && burst_inc == BURST_MAX && |(bus.req & ~gnt_q);
    rel = state_q == ST_GRANT && (!bus.req[owner_q] || rotate);
    state_d = grant ? ST_GRANT : rel ? ST_IDLE : state_q;
    gnt_d = grant ? pick : rel ? '0 : gnt_q;
    owner_d = grant ? pick_idx : owner_q;
    ptr_d = rel ? (owner_q == IDX_W'(NUM_REQ - 1) ? '0 : owner_q + 1'b1) : ptr_q;
    burst_d = grant ? '0 : write ? burst_inc : burst_q;
    wr_pulse_d = write;
  end
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NUM_REQ; i++) wsel = owner_q == IDX_W'(i) ? bus.wdata[i*DATA_W +: DATA_W] : wsel;
    q_d = write ? wsel : q_q;
    bus.gnt = gnt_q;
    bus.q = q_q;
    bus.wr_pulse = wr_pulse_q;
    bus.busy = |gnt_q;
  end
`ifdef ARB_GNT_COUNT_EN
  logic [NUM_REQ-1:0][GNT_CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = cnt_q[i] + GNT_CNT_W'(grant && pick[i] && cnt_q[i] != '1);
  end
  assign bus.gnt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and random stimulus checked against a rule-level reference model.
module tb_dff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dff_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  dff_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  int compared = 0;
  int mismatched = 0;
  int m_own, m_ptr, m_burst, m_wr;
  int m_q;
  int m_cnt[N];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_own = -1;
    m_ptr = 0;
    m_burst = 0;
    m_wr = 0;
    m_q = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask
  // One clock edge of the arbitration rules, using the inputs present at that edge.
  task automatic m_step();
    int r;
    int others;
    r = int'(bus.req);
    m_wr = 0;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && ((r >> ((m_ptr + k) % N)) & 1) == 1) m_own = (m_ptr + k) % N;
      if (m_own >= 0) begin
        m_burst = 0;
        if (m_cnt[m_own] < 255) m_cnt[m_own]++;
      end
    end else if (((r >> m_own) & 1) == 0) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else begin
      m_q = int'(bus.wdata[m_own*W +: W]);
      m_wr = 1;
      m_burst = m_burst + 1 > MB ? MB : m_burst + 1;
      others = r & ~(1 << m_own);
      if (m_burst == MB && others != 0) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".gnt"}, 64'(bus.gnt), m_own < 0 ? 64'd0 : 64'(1) << m_own);
    check({tag, ".q"}, 64'(bus.q), 64'(m_q));
    check({tag, ".wr_pulse"}, 64'(bus.wr_pulse), 64'(m_wr));
    check({tag, ".busy"}, 64'(bus.busy), 64'(m_own >= 0));
`ifdef ARB_GNT_COUNT_EN
    for (int i = 0; i < N; i++) check({tag, ".gnt_cnt"}, 64'(bus.gnt_cnt[i*8 +: 8]), 64'(m_cnt[i]));
`endif
  endtask
  task automatic cyc(input string tag, input int n);
    repeat (n) begin
      @(posedge clk);
      m_step();
      #1;
      check_all(tag);
    end
  endtask
  initial begin
    bus.req = '0;
    bus.wdata = '0;
    m_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;
    for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = W'(8'h10 + i);
    bus.req = 4'b1111;
    cyc("fair", 2);
    check("fair.first_q", 64'(bus.q), 64'h10);
    cyc("fair", 50);
`ifdef ARB_GNT_COUNT_EN
    bus.req = '0;
    cyc("fair_drain", 2);
`endif
    bus.req = '0;
    cyc("idle", 3);
    bus.req = 4'b0010;
    bus.wdata[1*W +: W] = 8'hA5;
    cyc("single", 4);
    check("single.q", 64'(bus.q), 64'hA5);
    bus.req = '0;
    cyc("single_drop", 2);
    bus.req = 4'b0100;
    cyc("to_ptr3", 3);
    bus.req = '0;
    cyc("to_ptr3", 2);
    bus.req = 4'b0101;
    cyc("wrap", 1);
    check("wrap.first", 64'(bus.gnt), 64'b0001);
    bus.req = 4'b0100;
    cyc("wrap", 2);
    check("wrap.second", 64'(bus.gnt), 64'b0100);
    bus.req = '0;
    cyc("wrap", 2);
    bus.req = 4'b1000;
    bus.wdata[3*W +: W] = 8'h3C;
    cyc("solo", 11);
    check("solo.busy", 64'(bus.busy), 64'd1);
    bus.req = 4'b1001;
    cyc("late", 8);
    bus.req = 4'b0100;
    bus.wdata[2*W +: W] = 8'h77;
    cyc("pre_rst", 4);
    bus.req = '0;
    cyc("pre_rst", 2);
    bus.req = 4'b0100;
    cyc("mid_burst", 3);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    #3 rst_n = 1'b1;
    bus.req = 4'b0001;
    cyc("post_rst", 1);
    check("post_rst.gnt", 64'(bus.gnt), 64'b0001);
    cyc("post_rst", 2);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, 15));
      bus.wdata = (N*W)'($urandom);
      cyc("rand", 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
